// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: 32-bit loads/stores over a 16-bit multi-cycle SRAM,
// split into low/high half-word accesses while the pipeline is frozen.
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               WB_EN_IN,
  input  logic               MEM_R_EN_IN,
  input  logic               MEM_W_EN_IN,
  input  logic [31:0]        ALU_Res_in,
  input  logic [31:0]        Val_Rm_in,
  input  logic [3:0]         Dest_in,
  output logic               WB_EN,
  output logic               MEM_R_EN,
  output logic [31:0]        ALU_Res,
  output logic [3:0]         Dest,
  output logic [31:0]        Mem_Data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [31:0]        mem_data_q;
  logic               we_n_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [15:0]        wdata_q;

  logic [31:0]        off;
  logic [SRAM_AW-2:0] word;
  logic               req;
  logic               is_wr;
  logic               last;
  logic               unused_off;

  assign off        = ALU_Res_in - 32'(BASE_ADDR);
  assign word       = off[SRAM_AW:2];
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
  assign req        = MEM_R_EN_IN | MEM_W_EN_IN;
  // a simultaneous read+write request is treated as a plain read
  assign is_wr      = MEM_W_EN_IN & ~MEM_R_EN_IN;
  assign last       = (cnt_q == CW'(WAIT_CYCLES - 1));

  assign WB_EN      = WB_EN_IN;
  assign MEM_R_EN   = MEM_R_EN_IN;
  assign ALU_Res    = ALU_Res_in;
  assign Dest       = Dest_in;
  assign Mem_Data   = mem_data_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_we_n  = we_n_q;
  assign ready      = ((state_q == IDLE) & ~req) | (state_q == DONE);

  // SRAM strobes are loaded one edge early so they line up with LO/HI
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_data_q <= '0;
      we_n_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= LO;
            cnt_q   <= '0;
            addr_q  <= {word, 1'b0};
            wdata_q <= Val_Rm_in[15:0];
            we_n_q  <= ~is_wr;
          end
        end
        LO: begin
          if (last) begin
            state_q <= HI;
            cnt_q   <= '0;
            addr_q  <= {word, 1'b1};
            wdata_q <= Val_Rm_in[31:16];
            if (MEM_R_EN_IN) mem_data_q[15:0] <= sram_rdata;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HI: begin
          if (last) begin
            state_q <= DONE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
            if (MEM_R_EN_IN) mem_data_q[31:16] <= sram_rdata;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Randomized bench for mem_stage_sram_ctrl with an op-level timing model
// and a multi-cycle SRAM that only honours the last cycle of each half.
module tb_mem_stage_sram_ctrl;
  localparam int BASE = 1024;
  localparam int W    = 3;
  localparam int AW   = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wb_i, r_i, w_i;
  logic [31:0]   alu_i, val_i;
  logic [3:0]    dst_i;
  logic          WB_EN, MEM_R_EN, ready, sram_we_n;
  logic [31:0]   ALU_Res, Mem_Data;
  logic [3:0]    Dest;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata, sram_rdata;

  logic [15:0]   sram [0:(1<<AW)-1];
  logic [15:0]   refm [0:(1<<AW)-1];
  logic          rd_last;
  logic [31:0]   md_m;
  int            n_vec = 0;
  int            n_err = 0;

  mem_stage_sram_ctrl #(
    .BASE_ADDR(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .WB_EN_IN(wb_i), .MEM_R_EN_IN(r_i), .MEM_W_EN_IN(w_i),
    .ALU_Res_in(alu_i), .Val_Rm_in(val_i), .Dest_in(dst_i),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALU_Res(ALU_Res),
    .Dest(Dest), .Mem_Data(Mem_Data), .ready(ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_we_n(sram_we_n)
  );

  // data is only valid in the last cycle of a half; otherwise garbage
  always_comb sram_rdata = rd_last ? sram[sram_addr] : ~sram[sram_addr];

  always @(posedge clk)
    if (rd_last && !sram_we_n) sram[sram_addr] <= sram_wdata;

  function automatic void chk(string nm, logic [31:0] got,
                              logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endfunction

  task automatic cyc(input logic e_rdy, input logic [AW-1:0] e_addr,
                     input logic e_we, input logic [15:0] e_wd,
                     input bit ck_wd, input logic [31:0] e_md,
                     output logic s_rdy, output logic s_we);
    @(negedge clk);
    chk("ready", 32'(ready), 32'(e_rdy));
    chk("sram_addr", 32'(sram_addr), 32'(e_addr));
    chk("sram_we_n", 32'(sram_we_n), 32'(e_we));
    if (ck_wd) chk("sram_wdata", 32'(sram_wdata), 32'(e_wd));
    chk("Mem_Data", Mem_Data, e_md);
    chk("WB_EN", 32'(WB_EN), 32'(wb_i));
    chk("MEM_R_EN", 32'(MEM_R_EN), 32'(r_i));
    chk("ALU_Res", ALU_Res, alu_i);
    chk("Dest", 32'(Dest), 32'(dst_i));
    s_rdy = ready;
    s_we  = sram_we_n;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit r, input bit w, input logic [31:0] a,
                    input logic [31:0] d, input bit wb,
                    input logic [3:0] dst, input int stop_k,
                    output int rlow, output int wlow);
    logic [31:0]   off;
    logic [AW-1:0] lo, hi, e_addr;
    logic [15:0]   e_wd;
    logic [31:0]   e_md;
    logic          s_rdy, s_we;
    bit            st, in_lo, in_hi;
    wb_i = wb; r_i = r; w_i = w;
    alu_i = a; val_i = d; dst_i = dst;
    off  = a - 32'(BASE);
    lo   = AW'((off >> 2) * 2);
    hi   = lo + 1'b1;
    rlow = 0;
    wlow = 0;
    if (!(r || w)) begin
      rd_last = 1'b0;
      cyc(1'b1, '0, 1'b1, 16'h0, 1'b1, md_m, s_rdy, s_we);
      return;
    end
    st = w && !r;
    for (int k = 0; k <= 2*W+1; k++) begin
      in_lo  = (k >= 1) && (k <= W);
      in_hi  = (k > W) && (k <= 2*W);
      e_addr = in_lo ? lo : (in_hi ? hi : '0);
      e_wd   = in_lo ? d[15:0] : (in_hi ? d[31:16] : 16'h0);
      e_md   = md_m;
      if (r && k > W) e_md[15:0] = refm[lo];
      if (r && k == 2*W+1) e_md[31:16] = refm[hi];
      rd_last = (k == W) || (k == 2*W);
      if (k == stop_k) rst = 1'b1;
      cyc(k == 2*W+1, e_addr, !(st && (in_lo || in_hi)), e_wd,
          st || !(in_lo || in_hi), e_md, s_rdy, s_we);
      if (!s_rdy) rlow++;
      if (!s_we) wlow++;
      if (k == stop_k) begin
        rst  = 1'b0;
        md_m = '0;
        if (st) refm[lo] = d[15:0];
        return;
      end
    end
    if (st) begin
      refm[lo] = d[15:0];
      refm[hi] = d[31:16];
      chk("sram_lo", 32'(sram[lo]), 32'(d[15:0]));
      chk("sram_hi", 32'(sram[hi]), 32'(d[31:16]));
    end
    if (r) md_m = {refm[hi], refm[lo]};
  endtask

  initial begin
    int          rl, wl, t;
    logic        s_rdy, s_we;
    logic [31:0] a;
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i] <= 16'(i * 40503 + 7);
      refm[i] = 16'(i * 40503 + 7);
    end
    sram[2] <= 16'hBEEF; refm[2] = 16'hBEEF;
    sram[3] <= 16'hDEAD; refm[3] = 16'hDEAD;
    sram[4] <= 16'hCAFE; refm[4] = 16'hCAFE;
    sram[5] <= 16'hF00D; refm[5] = 16'hF00D;
    rst = 1'b1; rd_last = 1'b0;
    wb_i = 0; r_i = 0; w_i = 0;
    alu_i = '0; val_i = '0; dst_i = '0;
    md_m = '0;
    @(posedge clk);
    #1;
    cyc(1'b1, '0, 1'b1, 16'h0, 1'b1, 32'h0, s_rdy, s_we);
    rst = 1'b0;

    op(0, 0, 32'h55, 32'h0, 1, 4'd3, -1, rl, wl);
    chk("nm_rlow", rl, 0);

    op(1, 0, 32'd1028, 32'h0, 1, 4'd5, -1, rl, wl);
    chk("ld_rlow", rl, 7);
    chk("ld_data", Mem_Data, 32'hDEADBEEF);

    op(0, 1, 32'd1024, 32'h12345678, 0, 4'd0, -1, rl, wl);
    chk("st_rlow", rl, 7);
    chk("st_wlow", wl, 6);
    chk("st_sram0", 32'(sram[0]), 32'h5678);
    chk("st_sram1", 32'(sram[1]), 32'h1234);
    chk("st_md_keep", Mem_Data, 32'hDEADBEEF);

    op(1, 0, 32'd1024, 32'h0, 1, 4'd1, -1, rl, wl);
    chk("b2b1_rlow", rl, 7);
    chk("b2b1_data", Mem_Data, 32'h12345678);
    op(1, 0, 32'd1032, 32'h0, 1, 4'd2, -1, rl, wl);
    chk("b2b2_rlow", rl, 7);
    chk("b2b2_data", Mem_Data, 32'hF00DCAFE);

    op(1, 1, 32'd1024, 32'hFFFFFFFF, 1, 4'd6, -1, rl, wl);
    chk("rw_wlow", wl, 0);
    chk("rw_data", Mem_Data, 32'h12345678);
    chk("rw_sram0", 32'(sram[0]), 32'h5678);

    op(0, 1, 32'd1024, 32'hAAAA5555, 0, 4'd0, W+1, rl, wl);
    op(0, 0, 32'h0, 32'h0, 0, 4'd0, -1, rl, wl);
    chk("rst_md", Mem_Data, 32'h0);
    chk("rst_sram0", 32'(sram[0]), 32'h5555);
    chk("rst_sram1", 32'(sram[1]), 32'h1234);

    for (int n = 0; n < 150; n++) begin
      t = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
      op(t == 1 || t == 3, t == 2 || t == 3, a, $urandom,
         1'($urandom), 4'($urandom), -1, rl, wl);
      if (t != 0) chk("rnd_rlow", rl, 2*W+1);
      if (t == 2) chk("rnd_wlow", wl, 2*W);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory stage of the pipelined core; sits directly downstream of the EXE/MEM pipeline register and feeds the MEM/WB register.
- Performs 32-bit loads and stores against an external 16-bit-wide, multi-cycle SRAM by splitting each word into two half-word accesses.
- Drives `ready` low while an access is in flight; `ready=0` freezes every upstream stage and the pipeline registers.
- Passes the writeback controls, ALU result and destination through to writeback.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM half-word 0.
- WAIT_CYCLES, 3: cycles each half-word access occupies; legal range is 1 or more.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- WB_EN_IN  in  1  writeback enable from EXE/MEM register.
- MEM_R_EN_IN  in  1  load request.
- MEM_W_EN_IN  in  1  store request.
- ALU_Res_in  in  32  effective byte address, or ALU result for non-memory ops.
- Val_Rm_in  in  32  store data.
- Dest_in  in  4  destination register.
- WB_EN  out  1  pass-through of WB_EN_IN.
- MEM_R_EN  out  1  pass-through of MEM_R_EN_IN.
- ALU_Res  out  32  pass-through of ALU_Res_in.
- Dest  out  4  pass-through of Dest_in.
- Mem_Data  out  32  registered load result.
- ready  out  1  1 = stage may advance; 0 = freeze pipeline.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_wdata  out  16  SRAM write data.
- sram_rdata  in  16  SRAM read data, valid during the last cycle of each half access.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates on the posedge of clk.
- Reset values: state=IDLE, counter=0, Mem_Data=0, sram_we_n=1, sram_addr=0, sram_wdata=0.
- Pass-throughs: WB_EN, MEM_R_EN, ALU_Res and Dest are combinational copies of their inputs.
- Address mapping:
  - off = ALU_Res_in - BASE_ADDR, 32-bit wrapping subtraction.
  - word = off[SRAM_AW:2].
  - Low half is at {word,0}; high half is at {word,1}.
  - Addresses beyond the SRAM wrap modulo 2^SRAM_AW; no error is flagged.
- Request decode:
  - req = MEM_R_EN_IN | MEM_W_EN_IN.
  - If both are asserted, the access is treated as a read and no write occurs.
- States: IDLE, LO, HI, DONE.
  - IDLE:
    - If req=0: ready=1 and state stays IDLE.
    - If req=1: ready=0, counter cleared, next state is LO.
  - LO:
    - sram_addr={word,0}; for a store, sram_wdata=Val_Rm_in[15:0] and sram_we_n=0.
    - The counter counts 0 to WAIT_CYCLES-1.
    - On the last count, a load captures sram_rdata into Mem_Data[15:0]; the counter clears and next state is HI.
  - HI:
    - Same as LO, but using address {word,1}, Val_Rm_in[31:16] and Mem_Data[31:16].
    - On the last count, next state is DONE.
  - DONE:
    - ready=1 and sram_we_n=1; next state is IDLE.
    - The upstream pipeline advances on this edge, so a held request is not re-issued.
- Outside LO and HI: sram_we_n=1, sram_addr=0, sram_wdata=0.
- Latency: ready is low for exactly 1+2*WAIT_CYCLES cycles per memory op, then high for one cycle in DONE.
- Mem_Data:
  - Valid from the DONE cycle onward.
  - Holds its value until the next load's LO capture.
  - Stores and non-memory ops leave it unchanged.
- Input stability: upstream holds all inputs stable while ready=0, guaranteed by the freeze. The block does not re-sample inputs mid-access.
- Back-to-back memory ops: DONE is followed by IDLE, so the next op starts in IDLE. Each op has a 1-cycle ready=1 gap.
- Reset mid-access:
  - The next state is IDLE and sram_we_n=1 immediately on that edge.
  - A partial store may have written only the low half; this is accepted.
  - Mem_Data returns to 0.

Test Plan:
- Non-memory op: WB_EN_IN=1, R=W=0, ALU_Res_in=0x55, Dest_in=3 -> ready stays 1, sram_we_n=1, outputs mirror inputs the same cycle.
- Load at WAIT_CYCLES=3, ALU_Res_in=1028 (SRAM[2]=0xBEEF, SRAM[3]=0xDEAD) -> ready low 7 cycles; sram_addr=2 for 3 cycles, then 3 for 3 cycles; Mem_Data=0xDEADBEEF in DONE, ready=1 there.
- Store of 0x12345678 at 1024 -> SRAM[0]=0x5678, SRAM[1]=0x1234; sram_we_n low for exactly 6 cycles; Mem_Data unchanged; ready low 7 cycles.
- Two consecutive loads at 1024 then 1032 -> each op has ready low 7 cycles, separated by exactly one ready=1 cycle; second Mem_Data reflects SRAM[4..5].
- Both R and W asserted at 1024 with Val_Rm_in=0xFFFFFFFF -> sram_we_n never low, SRAM contents unchanged, Mem_Data={SRAM[1],SRAM[0]}.
- rst pulsed in the HI state of a store -> next cycle state=IDLE, sram_we_n=1, Mem_Data=0; SRAM[0] written, SRAM[1] untouched; ready=1 if inputs are deasserted.
